// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debouncer and related pin-conditioning blocks.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE   = 2'b00,
        HIGH_CONFIRM = 2'b01,
        HIGH_STABLE  = 2'b11,
        LOW_CONFIRM  = 2'b10
    } deb_state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_chain.sv
// Generic multi-flop synchronizer for a single asynchronous bit; q is the last stage.
module sync_chain #(
    parameter int SYNC_STAGES = debounce_pkg::DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    // d feeds flop 0 directly; nothing combinational in front of the first stage
    always_ff @(posedge clk) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a raw switch/pin into the clean level w, with one-cycle edge strobes.
//
//  state        | meaning
//  LOW_STABLE   | w=0, synced input agrees
//  HIGH_CONFIRM | w=0, synced input high, counting consecutive high samples
//  HIGH_STABLE  | w=1, synced input agrees
//  LOW_CONFIRM  | w=1, synced input low, counting consecutive low samples
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic w,
    output logic rise_p,
    output logic fall_p
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit BYPASS = (STABLE_CYCLES == 1);

    logic             s;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_d, rise_d, fall_d;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_in),
        .q     (s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
            w       <= 1'b0;
            rise_p  <= 1'b0;
            fall_p  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w       <= w_d;
            rise_p  <= rise_d;
            fall_p  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            LOW_STABLE: begin
                cnt_d = '0;
                if (s) begin
                    if (BYPASS) begin
                        state_d = HIGH_STABLE;
                        w_d     = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = HIGH_CONFIRM;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            HIGH_CONFIRM: begin
                if (!s) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                    w_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH_STABLE: begin
                cnt_d = '0;
                if (!s) begin
                    if (BYPASS) begin
                        state_d = LOW_STABLE;
                        w_d     = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = LOW_CONFIRM;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            LOW_CONFIRM: begin
                if (s) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                    w_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized self-checking bench for input_debouncer against a sample-window reference model.
module tb_input_debouncer;

    localparam int S  = 2;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic raw_in, raw1;
    logic w, rise_p, fall_p;
    logic w1, rise1, fall1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    input_debouncer #(.SYNC_STAGES(S), .STABLE_CYCLES(SC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_in (raw_in),
        .w      (w),
        .rise_p (rise_p),
        .fall_p (fall_p)
    );

    input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_in (raw1),
        .w      (w1),
        .rise_p (rise1),
        .fall_p (fall1)
    );

    // Reference: w flips when the last SC samples seen through an S-deep pipe all disagree with it.
    bit   hist [0:8191];
    int   e = 0;
    logic m_w = 1'b0, m_rise = 1'b0, m_fall = 1'b0;

    always @(posedge clk) begin
        bit all_diff;
        e++;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!rst_n) begin
            for (int i = e - S - SC; i <= e; i++) if (i >= 0) hist[i] = 1'b0;
            m_w = 1'b0;
        end else begin
            hist[e] = raw_in;
            if (e - S - SC + 1 >= 0) begin
                all_diff = 1'b1;
                for (int i = e - S - SC + 1; i <= e - S; i++)
                    if (hist[i] == m_w) all_diff = 1'b0;
                if (all_diff) begin
                    m_w = ~m_w;
                    if (m_w) m_rise = 1'b1;
                    else     m_fall = 1'b1;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        raw_in = 1'b1;
        raw1   = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if ({w, rise_p, fall_p} !== 3'b000)
                $display("FAIL reset[%0d]: w/rise/fall=%b required 000", j, {w, rise_p, fall_p});
            else n_pass++;
        end
        raw_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            n_checks++;
            if ({w, rise_p, fall_p} !== 3'b000)
                $display("FAIL idle_low[%0d]: w/rise/fall=%b required 000", j, {w, rise_p, fall_p});
            else n_pass++;
        end
    endtask

    task automatic test_clean_rise();
        logic [2:0] exp;
        raw_in = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            exp = {(j >= 5), (j == 5), 1'b0};
            n_checks++;
            if ({w, rise_p, fall_p} !== exp)
                $display("FAIL clean_rise[edge k+%0d]: w/rise/fall=%b required %b", j, {w, rise_p, fall_p}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic pat [0:6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int rises = 0;
        int rise_j = -1;
        raw_in = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            n_checks++;
            if ({w, rise_p, fall_p} !== {m_w, m_rise, m_fall})
                $display("FAIL bounce_setup[%0d]: w/rise/fall=%b required %b", j, {w, rise_p, fall_p}, {m_w, m_rise, m_fall});
            else n_pass++;
        end
        for (int j = 0; j < 18; j++) begin
            raw_in = (j < 7) ? pat[j] : 1'b1;
            @(negedge clk);
            if (rise_p) begin rises++; rise_j = j; end
            n_checks++;
            if ({w, rise_p, fall_p} !== {m_w, m_rise, m_fall})
                $display("FAIL bounce[%0d]: w/rise/fall=%b required %b", j, {w, rise_p, fall_p}, {m_w, m_rise, m_fall});
            else n_pass++;
        end
        n_checks++;
        if (rises !== 1 || rise_j !== 12)
            $display("FAIL bounce_rise_count: got %0d rises at %0d, required 1 at 12", rises, rise_j);
        else n_pass++;
    endtask

    task automatic test_glitch();
        for (int j = 0; j < 13; j++) begin
            raw_in = (j < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_checks++;
            if ({w, rise_p, fall_p} !== 3'b100)
                $display("FAIL glitch[%0d]: w/rise/fall=%b required 100", j, {w, rise_p, fall_p});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_confirm();
        logic [2:0] exp;
        rst_n  = 1'b0;
        raw_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({w, rise_p, fall_p} !== 3'b000)
            $display("FAIL reset_from_high: w/rise/fall=%b required 000", {w, rise_p, fall_p});
        else n_pass++;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        raw_in = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_checks++;
            if ({w, rise_p, fall_p} !== 3'b000)
                $display("FAIL pre_abort[%0d]: w/rise/fall=%b required 000", j, {w, rise_p, fall_p});
            else n_pass++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({w, rise_p, fall_p} !== 3'b000)
            $display("FAIL abort: w/rise/fall=%b required 000", {w, rise_p, fall_p});
        else n_pass++;
        rst_n = 1'b1;
        for (int j = 1; j < 9; j++) begin
            @(negedge clk);
            exp = {(j >= 6), (j == 6), 1'b0};
            n_checks++;
            if ({w, rise_p, fall_p} !== exp)
                $display("FAIL post_abort[r+%0d]: w/rise/fall=%b required %b", j, {w, rise_p, fall_p}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int left = 0;
        for (int j = 0; j < 800; j++) begin
            if (left == 0) begin
                raw_in = 1'($urandom_range(0, 1));
                left   = (($urandom_range(0, 3)) == 0) ? $urandom_range(4, 9) : $urandom_range(1, 4);
            end
            left--;
            rst_n = ($urandom_range(0, 149) != 0);
            @(negedge clk);
            n_checks++;
            if ({w, rise_p, fall_p} !== {m_w, m_rise, m_fall} || (rise_p && fall_p))
                $display("FAIL random[%0d]: w/rise/fall=%b required %b", j, {w, rise_p, fall_p}, {m_w, m_rise, m_fall});
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_cycle_pulse();
        logic [2:0] exp;
        raw1 = 1'b0;
        repeat (4) @(negedge clk);
        raw1 = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            raw1 = 1'b0;
            exp = {(j == 2), (j == 2), (j == 3)};
            n_checks++;
            if ({w1, rise1, fall1} !== exp)
                $display("FAIL sc1_pulse[edge k+%0d]: w/rise/fall=%b required %b", j, {w1, rise1, fall1}, exp);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        raw_in = 1'b0;
        raw1   = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_rise();
        test_bounce();
        test_glitch();
        test_reset_mid_confirm();
        test_random();
        test_single_cycle_pulse();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
